// File: rtl/video_pattern_pkg.sv
// Shared mode encodings, colour-bar table and mode-FSM types for the
// video test-pattern source.
package video_pattern_pkg;

  localparam int NUM_MODES = 6;

  typedef enum logic [2:0] {
    MODE_RED   = 3'd0,
    MODE_GREEN = 3'd1,
    MODE_BLUE  = 3'd2,
    MODE_BARS  = 3'd3,
    MODE_CHECK = 3'd4,
    MODE_GRAD  = 3'd5
  } mode_e;

  typedef enum logic {
    ST_HOLD    = 1'b0,
    ST_PENDING = 1'b1
  } mode_state_e;

  localparam logic [23:0] RGB_WHITE = 24'hFF_FF_FF;
  localparam logic [23:0] RGB_BLACK = 24'h00_00_00;

  // Colour-bar table, left to right across the line.
  function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
    logic [23:0] rgb;
    case (idx)
      3'd0:    rgb = 24'hFF_FF_FF;
      3'd1:    rgb = 24'hFF_FF_00;
      3'd2:    rgb = 24'h00_FF_FF;
      3'd3:    rgb = 24'h00_FF_00;
      3'd4:    rgb = 24'hFF_00_FF;
      3'd5:    rgb = 24'hFF_00_00;
      3'd6:    rgb = 24'h00_00_FF;
      3'd7:    rgb = 24'h00_00_00;
      default: rgb = 24'h00_00_00;
    endcase
    return rgb;
  endfunction

  function automatic mode_e next_mode(input mode_e m);
    mode_e n;
    if (m == MODE_GRAD) n = MODE_RED;
    else                n = mode_e'(m + 3'd1);
    return n;
  endfunction

endpackage

// File: rtl/pixel_pos_counter.sv
// Pixel x/y tracking from the timing strobes, plus a divider-free colour-bar
// index (bar-width counter feeding a bar index counter).
module pixel_pos_counter
  import video_pattern_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720,
  parameter int CNT_W    = 12
) (
  input  logic             pixel_clk,
  input  logic             resetn,
  input  logic             active,
  input  logic             fsync,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic [2:0]       bar_idx
);

  localparam logic [CNT_W-1:0] X_MAX   = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] Y_MAX   = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] BAR_MAX = CNT_W'(H_ACTIVE / 8 - 1);

  logic [CNT_W-1:0] x_r;
  logic [CNT_W-1:0] y_r;
  logic [CNT_W-1:0] bar_cnt_r;
  logic [2:0]       bar_idx_r;
  logic             active_d_r;
  logic             active_fall_s;

  assign active_fall_s = active_d_r & ~active;

  // Position and bar counters; x and the bar counters restart whenever active is low.
  always_ff @(posedge pixel_clk) begin
    if (!resetn) begin
      x_r        <= '0;
      y_r        <= '0;
      bar_cnt_r  <= '0;
      bar_idx_r  <= 3'd0;
      active_d_r <= 1'b0;
    end else begin
      active_d_r <= active;
      if (active) begin
        if (x_r != X_MAX) x_r <= x_r + CNT_W'(1);
        else              x_r <= x_r;
        if (bar_cnt_r == BAR_MAX) begin
          bar_cnt_r <= '0;
          if (bar_idx_r != 3'd7) bar_idx_r <= bar_idx_r + 3'd1;
          else                   bar_idx_r <= bar_idx_r;
        end else begin
          bar_cnt_r <= bar_cnt_r + CNT_W'(1);
          bar_idx_r <= bar_idx_r;
        end
      end else begin
        x_r       <= '0;
        bar_cnt_r <= '0;
        bar_idx_r <= 3'd0;
      end
      // fsync takes priority over a line ending in the same cycle
      if (fsync)                               y_r <= '0;
      else if (active_fall_s && (y_r != Y_MAX)) y_r <= y_r + CNT_W'(1);
      else                                     y_r <= y_r;
    end
  end

  assign x       = x_r;
  assign y       = y_r;
  assign bar_idx = bar_idx_r;

endmodule

// File: rtl/video_pattern_gen.sv
// Multi-mode HDMI test-pattern source with manual or dwell-timed auto cycling.
// Optional build macro PATTERN_GEN_BORDER_EN adds a one-pixel white frame border.
module video_pattern_gen
  import video_pattern_pkg::*;
#(
  parameter int H_ACTIVE     = 1280,
  parameter int V_ACTIVE     = 720,
  parameter int DWELL_CYCLES = 150000000,
  parameter int CHECK_LOG2   = 5,
  parameter int GRAD_SHIFT   = 3,
  parameter int CNT_W        = 12
) (
  input  logic       pixel_clk,
  input  logic       resetn,
  input  logic       active,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       fsync,
  input  logic       auto_en,
  input  logic [2:0] mode_sel,
  output logic [7:0] pdata_r,
  output logic [7:0] pdata_g,
  output logic [7:0] pdata_b,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       active_o,
  output logic [2:0] mode_o
);

  localparam int                 DWELL_W  = $clog2(DWELL_CYCLES + 1);
  localparam logic [DWELL_W-1:0] DWELL_TC = DWELL_W'(DWELL_CYCLES - 1);

  logic [CNT_W-1:0]   x_s;
  logic [CNT_W-1:0]   y_s;
  logic [2:0]         bar_idx_s;
  logic [CNT_W-1:0]   check_s;
  logic [7:0]         grey_s;
  logic [23:0]        patt_s;
  logic [23:0]        pix_s;

  mode_state_e        state_r, state_nxt_s;
  mode_e              mode_r, mode_nxt_s;
  logic [DWELL_W-1:0] dwell_r, dwell_nxt_s;
  logic               dwell_tc_s;

  logic [23:0]        rgb_out_r;
  logic               hsync_out_r;
  logic               vsync_out_r;
  logic               active_out_r;

  pixel_pos_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .CNT_W    (CNT_W)
  ) u_pos (
    .pixel_clk (pixel_clk),
    .resetn    (resetn),
    .active    (active),
    .fsync     (fsync),
    .x         (x_s),
    .y         (y_s),
    .bar_idx   (bar_idx_s)
  );

  assign dwell_tc_s = (dwell_r == DWELL_TC);

  // Mode FSM next-state: dwell timer, pending advance and manual select.
  always_comb begin
    state_nxt_s = state_r;
    mode_nxt_s  = mode_r;
    dwell_nxt_s = dwell_r;
    if (auto_en) begin
      if (dwell_tc_s) dwell_nxt_s = '0;
      else            dwell_nxt_s = dwell_r + DWELL_W'(1);
      case (state_r)
        ST_HOLD: begin
          if (dwell_tc_s) state_nxt_s = ST_PENDING;
          else            state_nxt_s = ST_HOLD;
        end
        ST_PENDING: begin
          if (fsync) begin
            mode_nxt_s  = next_mode(mode_r);
            state_nxt_s = dwell_tc_s ? ST_PENDING : ST_HOLD;
          end else begin
            state_nxt_s = ST_PENDING;
          end
        end
        default: state_nxt_s = ST_HOLD;
      endcase
    end else begin
      dwell_nxt_s = '0;
      state_nxt_s = ST_HOLD;
      if (fsync && (mode_sel < 3'(NUM_MODES))) mode_nxt_s = mode_e'(mode_sel);
      else                                      mode_nxt_s = mode_r;
    end
  end

  // Mode FSM state register.
  always_ff @(posedge pixel_clk) begin
    if (!resetn) begin
      state_r <= ST_HOLD;
      mode_r  <= MODE_RED;
      dwell_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      mode_r  <= mode_nxt_s;
      dwell_r <= dwell_nxt_s;
    end
  end

  assign check_s = (x_s >> CHECK_LOG2) ^ (y_s >> CHECK_LOG2);
  assign grey_s  = 8'(x_s >> GRAD_SHIFT);

  // Pattern colour for the current pixel position and mode.
  always_comb begin
    patt_s = RGB_BLACK;
    case (mode_r)
      MODE_RED:   patt_s = 24'hFF_00_00;
      MODE_GREEN: patt_s = 24'h00_FF_00;
      MODE_BLUE:  patt_s = 24'h00_00_FF;
      MODE_BARS:  patt_s = bar_rgb(bar_idx_s);
      MODE_CHECK: begin
        if ((check_s & CNT_W'(1)) == '0) patt_s = RGB_WHITE;
        else                              patt_s = RGB_BLACK;
      end
      MODE_GRAD:  patt_s = {grey_s, grey_s, grey_s};
      default:    patt_s = RGB_BLACK;
    endcase
  end

`ifdef PATTERN_GEN_BORDER_EN
  logic border_s;
  assign border_s = (x_s == '0) || (x_s == CNT_W'(H_ACTIVE - 1)) ||
                    (y_s == '0) || (y_s == CNT_W'(V_ACTIVE - 1));
  assign pix_s    = border_s ? RGB_WHITE : patt_s;
`else
  assign pix_s    = patt_s;
`endif

  // Output stage: one cycle of latency, data blanked outside active video.
  always_ff @(posedge pixel_clk) begin
    if (!resetn) begin
      rgb_out_r    <= 24'h00_00_00;
      hsync_out_r  <= 1'b0;
      vsync_out_r  <= 1'b0;
      active_out_r <= 1'b0;
    end else begin
      rgb_out_r    <= active ? pix_s : 24'h00_00_00;
      hsync_out_r  <= hsync;
      vsync_out_r  <= vsync;
      active_out_r <= active;
    end
  end

  assign {pdata_r, pdata_g, pdata_b} = rgb_out_r;
  assign hsync_o  = hsync_out_r;
  assign vsync_o  = vsync_out_r;
  assign active_o = active_out_r;
  assign mode_o   = mode_r;

endmodule
